// File: rtl/present_drop_scheduler.sv
// Present drop scheduler: LFSR-randomised gap between drops counted in secClk
// ticks, with a ballPopped bonus drop and back-pressure from the slot flags.
module present_drop_scheduler #(
    parameter int unsigned MIN_GAP    = 3,
    parameter logic [2:0]  BONUS_MASK = 3'b000,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       enable,
    input  logic       secClk,
    input  logic       ballPopped,
    input  logic [2:0] slotsBusy,
    output logic       dropPresent,
    output logic [1:0] nxt_present,
    output logic [3:0] gapCnt,
    output logic       armed
);

    typedef enum logic [1:0] {IDLE, COUNT, ARMED, DROP} state_t;

    state_t     state, state_nxt;
    logic [7:0] lfsr, lfsr_nxt;
    logic [3:0] gap_load, gap_nxt;
    logic [1:0] type_nxt;
    logic       drop_nxt, armed_nxt, bonus;

    assign gap_load = 4'(MIN_GAP) + {2'b00, lfsr[1:0]};
    assign bonus    = ballPopped && (lfsr[7:5] == BONUS_MASK);

    // Taps x^8+x^6+x^5+x^4+1 on bits 7,5,4,3; all-zero lock-up reloads the seed
    always_comb begin
        lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        if (lfsr == '0)
            lfsr_nxt = LFSR_SEED;
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gapCnt;
        type_nxt  = nxt_present;
        drop_nxt  = 1'b0;
        armed_nxt = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            gap_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = COUNT;
                    gap_nxt   = gap_load;
                end
                COUNT: begin
                    if (bonus || (secClk && gapCnt <= 4'd1)) begin
                        state_nxt = ARMED;
                        gap_nxt   = '0;
                        armed_nxt = 1'b1;
                    end else if (secClk) begin
                        gap_nxt = gapCnt - 4'd1;
                    end
                end
                ARMED: begin
                    if (slotsBusy != 3'b111) begin
                        state_nxt = DROP;
                        drop_nxt  = 1'b1;
                        type_nxt  = lfsr[3:2];
                    end else begin
                        armed_nxt = 1'b1;
                    end
                end
                DROP: begin
                    state_nxt = COUNT;
                    gap_nxt   = gap_load;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            gapCnt      <= '0;
            dropPresent <= 1'b0;
            nxt_present <= '0;
            armed       <= 1'b0;
        end else begin
            state       <= state_nxt;
            lfsr        <= lfsr_nxt;
            gapCnt      <= gap_nxt;
            dropPresent <= drop_nxt;
            nxt_present <= type_nxt;
            armed       <= armed_nxt;
        end
    end

endmodule

// File: tb/tb_present_drop_scheduler.sv
// Self-checking bench for present_drop_scheduler: cycle reference model plus
// a queue of expected present types consumed on every observed drop.
module tb_present_drop_scheduler;

    localparam int unsigned MIN_GAP    = 3;
    localparam logic [2:0]  BONUS_MASK = 3'b000;
    localparam logic [7:0]  LFSR_SEED  = 8'hA5;

    logic       clk = 1'b0;
    logic       resetN;
    logic       enable;
    logic       secClk;
    logic       ballPopped;
    logic [2:0] slotsBusy;
    logic       dropPresent;
    logic [1:0] nxt_present;
    logic [3:0] gapCnt;
    logic       armed;

    present_drop_scheduler #(
        .MIN_GAP    (MIN_GAP),
        .BONUS_MASK (BONUS_MASK),
        .LFSR_SEED  (LFSR_SEED)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .enable      (enable),
        .secClk      (secClk),
        .ballPopped  (ballPopped),
        .slotsBusy   (slotsBusy),
        .dropPresent (dropPresent),
        .nxt_present (nxt_present),
        .gapCnt      (gapCnt),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_drops  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model
    typedef enum int {M_IDLE, M_COUNT, M_ARMED, M_DROP} mstate_t;
    mstate_t    m_st    = M_IDLE;
    logic [7:0] m_lfsr  = LFSR_SEED;
    int         m_gap   = 0;
    logic       m_drop  = 1'b0;
    logic       m_armed = 1'b0;
    logic [1:0] m_nxt   = 2'b00;
    logic [1:0] exp_q[$];

    always @(posedge clk or negedge resetN) begin
        logic [7:0] cur;
        if (!resetN) begin
            m_st = M_IDLE; m_lfsr = LFSR_SEED; m_gap = 0;
            m_drop = 1'b0; m_armed = 1'b0; m_nxt = 2'b00;
            exp_q.delete();
        end else begin
            cur    = m_lfsr;
            m_lfsr = (cur == 8'h00) ? LFSR_SEED : {cur[6:0], ^(cur & 8'b1011_1000)};
            m_drop = 1'b0;
            if (!enable) begin
                m_st = M_IDLE; m_gap = 0; m_armed = 1'b0;
            end else begin
                case (m_st)
                    M_IDLE: begin m_st = M_COUNT; m_gap = int'(MIN_GAP) + int'(cur[1:0]); end
                    M_COUNT: begin
                        if (ballPopped && cur[7:5] == BONUS_MASK) begin
                            m_st = M_ARMED; m_gap = 0; m_armed = 1'b1;
                        end else if (secClk) begin
                            if (m_gap == 1) begin m_st = M_ARMED; m_gap = 0; m_armed = 1'b1; end
                            else m_gap = m_gap - 1;
                        end
                    end
                    M_ARMED: begin
                        if (slotsBusy != 3'b111) begin
                            m_st = M_DROP; m_drop = 1'b1; m_armed = 1'b0; m_nxt = cur[3:2];
                            exp_q.push_back(cur[3:2]);
                        end
                    end
                    default: begin m_st = M_COUNT; m_gap = int'(MIN_GAP) + int'(cur[1:0]); end
                endcase
            end
        end
    end

    // Per-cycle comparison, sampled on the falling edge
    always @(negedge clk) begin
        check("dropPresent", 32'(dropPresent), 32'(m_drop));
        check("armed", 32'(armed), 32'(m_armed));
        check("gapCnt", 32'(gapCnt), 32'(m_gap));
        check("nxt_hold", 32'(nxt_present), 32'(m_nxt));
        if (dropPresent) begin
            n_drops++;
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("nxt_present", 32'(nxt_present), 32'(exp_q.pop_front()));
        end
    end

    logic      sec_run = 1'b0;
    int        sec_div = 0;
    initial begin
        secClk = 1'b0;
        forever begin
            @(negedge clk);
            secClk = 1'b0;
            if (sec_run) begin
                sec_div = sec_div + 1;
                if (sec_div == 16) begin
                    sec_div = 0;
                    secClk  = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_model(input mstate_t st, input int budget, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            found = (m_st == st);
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int unsigned d0;
        logic        found;
        int          g_save;
        resetN = 1'b0; enable = 1'b0; ballPopped = 1'b0; slotsBusy = 3'b000;

        // 1: reset values, then idle with enable low
        repeat (2) step();
        check("rst_drop", 32'(dropPresent), 32'd0);
        check("rst_nxt", 32'(nxt_present), 32'd0);
        check("rst_gap", 32'(gapCnt), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_lfsr", 32'(dut.lfsr), 32'(LFSR_SEED));
        resetN = 1'b1;
        d0 = n_drops;
        repeat (100) step();
        check("idle_no_drop", n_drops - d0, 32'd0);

        // 2: normal running, several drops
        enable = 1'b1; sec_run = 1'b1;
        step(); step();
        check("gap_load_rng", 32'(gapCnt >= 4'd3 && gapCnt <= 4'd6), 32'd1);
        d0 = n_drops;
        for (int i = 0; i < 3000 && (n_drops - d0) < 4; i++) step();
        check("normal_drops", 32'((n_drops - d0) >= 4), 32'd1);

        // 3: all slots busy at expiry
        slotsBusy = 3'b111;
        wait_model(M_ARMED, 1000, "full_reach_armed");
        d0 = n_drops;
        repeat (200) step();
        check("full_no_drop", n_drops - d0, 32'd0);
        check("full_armed", 32'(armed), 32'd1);
        slotsBusy = 3'b011;
        found = 1'b0;
        for (int i = 0; i < 2 && !found; i++) begin
            step();
            found = dropPresent;
        end
        check("release_drop", 32'(found), 32'd1);
        slotsBusy = 3'b000;

        // 4: bonus drop from ballPopped while gapCnt==5
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            step();
            found = (m_st == M_COUNT) && (m_gap == 5) && (m_lfsr[7:5] == BONUS_MASK);
        end
        check("bonus_search", 32'(found), 32'd1);
        ballPopped = 1'b1;
        step();
        ballPopped = 1'b0;
        check("bonus_armed", 32'(armed), 32'd1);
        check("bonus_gap", 32'(gapCnt), 32'd0);
        step();
        check("bonus_drop", 32'(dropPresent), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step();
            found = (m_st == M_COUNT) && (m_gap > 1) && !secClk && (m_lfsr[7:5] != BONUS_MASK);
        end
        check("nobonus_search", 32'(found), 32'd1);
        g_save = m_gap;
        ballPopped = 1'b1;
        step();
        ballPopped = 1'b0;
        check("nobonus_gap", 32'(gapCnt), 32'(g_save));
        check("nobonus_armed", 32'(armed), 32'd0);

        // 5: abort while armed, then re-enable
        slotsBusy = 3'b111;
        wait_model(M_ARMED, 1000, "abort_reach_armed");
        d0 = n_drops;
        enable = 1'b0;
        step();
        check("abort_armed", 32'(armed), 32'd0);
        check("abort_gap", 32'(gapCnt), 32'd0);
        slotsBusy = 3'b000;
        repeat (50) step();
        check("abort_no_drop", n_drops - d0, 32'd0);
        enable = 1'b1;
        step();
        check("reenable_gap", 32'(gapCnt), 32'(int'(MIN_GAP) + int'(m_lfsr[1:0] ^ m_lfsr[1:0]) + m_gap - int'(MIN_GAP)));
        check("reenable_rng", 32'(gapCnt >= 4'd3 && gapCnt <= 4'd6), 32'd1);

        // 6: asynchronous reset in the middle of a drop
        wait_model(M_DROP, 2000, "drop_for_reset");
        check("pre_reset_drop", 32'(dropPresent), 32'd1);
        #2 resetN = 1'b0;
        #1;
        check("async_drop", 32'(dropPresent), 32'd0);
        check("async_lfsr", 32'(dut.lfsr), 32'(LFSR_SEED));
        check("async_gap", 32'(gapCnt), 32'd0);
        step();
        resetN = 1'b1;
        repeat (150) step();

        check("sb_leftover", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
